// File: rtl/ipsxe_floating_point_pkg.sv
// Shared constants and types for the floating-point core input stages.
package ipsxe_floating_point_pkg;

  localparam int unsigned OpWidth   = 8;
  localparam int unsigned SkidDepth = 2;

  typedef logic [1:0] count_t;

  localparam count_t SkidFull = 2'd2;

endpackage

// File: rtl/ipsxe_floating_point_skid_v1_0.sv
// Two-entry skid FIFO with registered ready, explicit pop and a non-empty flag.
module ipsxe_floating_point_skid_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             pop,
  output logic             non_empty,
  output logic [WIDTH-1:0] head
);

  count_t           count_q, count_d;
  logic             ready_q;
  logic [WIDTH-1:0] entry0_q, entry1_q;
  logic             wr, rd;

  assign wr        = in_valid & ready_q;
  assign rd        = pop & non_empty;
  assign non_empty = (count_q != 2'd0);
  assign in_ready  = ready_q;
  assign head      = entry0_q;

  always_comb begin
    count_d = count_q;
    case ({wr, rd})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      ready_q  <= 1'b0;
      entry0_q <= '0;
      entry1_q <= '0;
    end else begin
      count_q <= count_d;
      ready_q <= (count_d < SkidFull);
      if (rd) begin
        // A write alongside a pop only happens at count 1, so it lands at the head.
        entry0_q <= (count_q == SkidFull) ? entry1_q : in_data;
      end else if (wr) begin
        if (count_q == 2'd0) entry0_q <= in_data;
        else                 entry1_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/ipsxe_floating_point_in_join_v1_0.sv
// AXI4-Stream input join: buffers A, B, OPERATION and emits one aligned registered beat.
// Optional tlast support via IPSXE_FLOATING_POINT_JOIN_TLAST_EN.
module ipsxe_floating_point_in_join_v1_0
  import ipsxe_floating_point_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned HAS_B         = 1,
  parameter int unsigned HAS_OPERATION = 1
) (
  input  logic                  i_aclk,
  input  logic                  i_rst,
  input  logic                  i_axi4s_a_tvalid,
  input  logic [DATA_WIDTH-1:0] i_axi4s_a_tdata,
  output logic                  o_axi4s_a_tready,
  input  logic                  i_axi4s_b_tvalid,
  input  logic [DATA_WIDTH-1:0] i_axi4s_b_tdata,
  output logic                  o_axi4s_b_tready,
  input  logic                  i_axi4s_operation_tvalid,
  input  logic [OpWidth-1:0]    i_axi4s_operation_tdata,
  output logic                  o_axi4s_operation_tready,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_a_tdata,
  output logic [DATA_WIDTH-1:0] o_b_tdata,
`ifdef IPSXE_FLOATING_POINT_JOIN_TLAST_EN
  input  logic                  i_axi4s_a_tlast,
  input  logic                  i_axi4s_b_tlast,
  input  logic                  i_axi4s_operation_tlast,
  output logic                  o_tlast,
`endif
  output logic [OpWidth-1:0]    o_operation_tdata
);

`ifdef IPSXE_FLOATING_POINT_JOIN_TLAST_EN
  localparam int unsigned LastW = 1;
`else
  localparam int unsigned LastW = 0;
`endif
  localparam int unsigned DW = DATA_WIDTH + LastW;
  localparam int unsigned OW = OpWidth + LastW;

  logic [DW-1:0] a_in, a_head, b_in, b_head;
  logic [OW-1:0] op_in, op_head;
  logic          a_ne, b_ne, op_ne;
  logic          join_ok, load;

`ifdef IPSXE_FLOATING_POINT_JOIN_TLAST_EN
  assign a_in  = {i_axi4s_a_tlast, i_axi4s_a_tdata};
  assign b_in  = {i_axi4s_b_tlast, i_axi4s_b_tdata};
  assign op_in = {i_axi4s_operation_tlast, i_axi4s_operation_tdata};
`else
  assign a_in  = i_axi4s_a_tdata;
  assign b_in  = i_axi4s_b_tdata;
  assign op_in = i_axi4s_operation_tdata;
`endif

  ipsxe_floating_point_skid_v1_0 #(.WIDTH(DW)) u_skid_a (
    .clk       (i_aclk),
    .rst       (i_rst),
    .in_valid  (i_axi4s_a_tvalid),
    .in_data   (a_in),
    .in_ready  (o_axi4s_a_tready),
    .pop       (load),
    .non_empty (a_ne),
    .head      (a_head)
  );

  // Disabled channels look permanently full of zeros so the join only waits on live ones.
  if (HAS_B != 0) begin : g_b
    ipsxe_floating_point_skid_v1_0 #(.WIDTH(DW)) u_skid_b (
      .clk       (i_aclk),
      .rst       (i_rst),
      .in_valid  (i_axi4s_b_tvalid),
      .in_data   (b_in),
      .in_ready  (o_axi4s_b_tready),
      .pop       (load),
      .non_empty (b_ne),
      .head      (b_head)
    );
  end else begin : g_no_b
    assign o_axi4s_b_tready = 1'b0;
    assign b_ne             = 1'b1;
    assign b_head           = '0;
  end

  if (HAS_OPERATION != 0) begin : g_op
    ipsxe_floating_point_skid_v1_0 #(.WIDTH(OW)) u_skid_op (
      .clk       (i_aclk),
      .rst       (i_rst),
      .in_valid  (i_axi4s_operation_tvalid),
      .in_data   (op_in),
      .in_ready  (o_axi4s_operation_tready),
      .pop       (load),
      .non_empty (op_ne),
      .head      (op_head)
    );
  end else begin : g_no_op
    assign o_axi4s_operation_tready = 1'b0;
    assign op_ne                    = 1'b1;
    assign op_head                  = '0;
  end

  assign join_ok = a_ne & b_ne & op_ne;
  assign load    = join_ok & (~o_valid | i_ready);

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      o_valid           <= 1'b0;
      o_a_tdata         <= '0;
      o_b_tdata         <= '0;
      o_operation_tdata <= '0;
`ifdef IPSXE_FLOATING_POINT_JOIN_TLAST_EN
      o_tlast           <= 1'b0;
`endif
    end else if (load) begin
      o_valid           <= 1'b1;
      o_a_tdata         <= a_head[DATA_WIDTH-1:0];
      o_b_tdata         <= b_head[DATA_WIDTH-1:0];
      o_operation_tdata <= op_head[OpWidth-1:0];
`ifdef IPSXE_FLOATING_POINT_JOIN_TLAST_EN
      o_tlast           <= a_head[DATA_WIDTH] | b_head[DATA_WIDTH] | op_head[OpWidth];
`endif
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_in_join_v1_0.sv
// Self-checking bench: a full join instance plus an A-only instance, scoreboarded with queues.
module tb_ipsxe_floating_point_in_join_v1_0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy;
  logic        a_v, b_v, op_v, s_v;
  logic [31:0] a_d, b_d, s_d;
  logic [7:0]  op_d;
  logic        a_l, b_l, op_l, s_l;

  logic        a_tready, b_tready, op_tready, o_valid;
  logic [31:0] o_a, o_b;
  logic [7:0]  o_op;
  logic        s_a_tready, s_b_tready, s_op_tready, s_valid;
  logic [31:0] s_a, s_b;
  logic [7:0]  s_op;
`ifdef IPSXE_FLOATING_POINT_JOIN_TLAST_EN
  logic        o_last, s_last;
`endif

  ipsxe_floating_point_in_join_v1_0 #(.DATA_WIDTH(32), .HAS_B(1), .HAS_OPERATION(1)) dut (
    .i_aclk                   (clk),
    .i_rst                    (rst),
    .i_axi4s_a_tvalid         (a_v),
    .i_axi4s_a_tdata          (a_d),
    .o_axi4s_a_tready         (a_tready),
    .i_axi4s_b_tvalid         (b_v),
    .i_axi4s_b_tdata          (b_d),
    .o_axi4s_b_tready         (b_tready),
    .i_axi4s_operation_tvalid (op_v),
    .i_axi4s_operation_tdata  (op_d),
    .o_axi4s_operation_tready (op_tready),
    .o_valid                  (o_valid),
    .i_ready                  (rdy),
    .o_a_tdata                (o_a),
    .o_b_tdata                (o_b),
`ifdef IPSXE_FLOATING_POINT_JOIN_TLAST_EN
    .i_axi4s_a_tlast          (a_l),
    .i_axi4s_b_tlast          (b_l),
    .i_axi4s_operation_tlast  (op_l),
    .o_tlast                  (o_last),
`endif
    .o_operation_tdata        (o_op)
  );

  // A-only instance; its B/OPERATION inputs see live traffic that must be ignored.
  ipsxe_floating_point_in_join_v1_0 #(.DATA_WIDTH(32), .HAS_B(0), .HAS_OPERATION(0)) dut_a (
    .i_aclk                   (clk),
    .i_rst                    (rst),
    .i_axi4s_a_tvalid         (s_v),
    .i_axi4s_a_tdata          (s_d),
    .o_axi4s_a_tready         (s_a_tready),
    .i_axi4s_b_tvalid         (b_v),
    .i_axi4s_b_tdata          (b_d),
    .o_axi4s_b_tready         (s_b_tready),
    .i_axi4s_operation_tvalid (op_v),
    .i_axi4s_operation_tdata  (op_d),
    .o_axi4s_operation_tready (s_op_tready),
    .o_valid                  (s_valid),
    .i_ready                  (rdy),
    .o_a_tdata                (s_a),
    .o_b_tdata                (s_b),
`ifdef IPSXE_FLOATING_POINT_JOIN_TLAST_EN
    .i_axi4s_a_tlast          (s_l),
    .i_axi4s_b_tlast          (b_l),
    .i_axi4s_operation_tlast  (op_l),
    .o_tlast                  (s_last),
`endif
    .o_operation_tdata        (s_op)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] qa[$], qb[$], sq[$];
  logic [7:0]  qo[$];
  bit          qla[$], qlb[$], qlo[$], sql[$];
  int          beats_out = 0, s_beats = 0;
  bit          held = 0, s_held = 0;
  logic [31:0] ha, hb, sh;
  logic [7:0]  ho;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard the current cycle's handshakes, then advance one clock.
  task automatic step();
    logic [31:0] ea, eb;
    logic [7:0]  eo;
    bit          la, lb, lo;
    if (!rst) begin
      if (a_v && a_tready) begin qa.push_back(a_d); qla.push_back(a_l); end
      if (b_v && b_tready) begin qb.push_back(b_d); qlb.push_back(b_l); end
      if (op_v && op_tready) begin qo.push_back(op_d); qlo.push_back(op_l); end
      if (s_v && s_a_tready) begin sq.push_back(s_d); sql.push_back(s_l); end
      if (o_valid) begin
        if (held) begin
          check("hold_a", o_a, ha);
          check("hold_b", o_b, hb);
          check("hold_op", o_op, ho);
        end
        if (rdy) begin
          if (qa.size() == 0 || qb.size() == 0 || qo.size() == 0) begin
            check("out_without_input", 1, 0);
          end else begin
            ea = qa.pop_front(); eb = qb.pop_front(); eo = qo.pop_front();
            la = qla.pop_front(); lb = qlb.pop_front(); lo = qlo.pop_front();
            check("out_a", o_a, ea);
            check("out_b", o_b, eb);
            check("out_op", o_op, eo);
`ifdef IPSXE_FLOATING_POINT_JOIN_TLAST_EN
            check("out_tlast", o_last, la | lb | lo);
`endif
          end
          beats_out++;
          held = 0;
        end else begin
          held = 1; ha = o_a; hb = o_b; ho = o_op;
        end
      end else begin
        held = 0;
      end
      if (s_valid) begin
        check("s_b_zero", s_b, 0);
        check("s_op_zero", s_op, 0);
        if (s_held) check("s_hold_a", s_a, sh);
        if (rdy) begin
          if (sq.size() == 0) begin
            check("s_out_without_input", 1, 0);
          end else begin
            ea = sq.pop_front();
            la = sql.pop_front();
            check("s_out_a", s_a, ea);
`ifdef IPSXE_FLOATING_POINT_JOIN_TLAST_EN
            check("s_out_tlast", s_last, la);
`endif
          end
          s_beats++;
          s_held = 0;
        end else begin
          s_held = 1; sh = s_a;
        end
      end else begin
        s_held = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Send n beats on every channel of both instances; rdy low for the first 'stall' cycles.
  task automatic stream(input int n, input int stall, input int budget, input bit gaps);
    int sa = 0, sb = 0, so = 0, ss = 0;
    int start = beats_out, s_start = s_beats, bubbles = 0;
    bit first = 0, done = 0;
    bit ah, bh, oh, sh_hs;
    a_v = 0; b_v = 0; op_v = 0; s_v = 0;
    for (int c = 0; c < budget && !done; c++) begin
      rdy = gaps ? 1'($urandom_range(0, 1)) : (c >= stall);
      if (!a_v && sa < n && (!gaps || $urandom_range(0, 3) != 0)) begin
        a_v = 1; a_d = $urandom; a_l = (sa == 3);
      end
      if (!b_v && sb < n && (!gaps || $urandom_range(0, 3) != 0)) begin
        b_v = 1; b_d = $urandom; b_l = (sb == 1);
      end
      if (!op_v && so < n && (!gaps || $urandom_range(0, 3) != 0)) begin
        op_v = 1; op_d = 8'($urandom); op_l = 0;
      end
      if (!s_v && ss < n && (!gaps || $urandom_range(0, 3) != 0)) begin
        s_v = 1; s_d = $urandom; s_l = (ss == 3);
      end
      if (stall > 0 && c == stall - 1) begin
        check("bp_a_tready", a_tready, 0);
        check("bp_b_tready", b_tready, 0);
        check("bp_op_tready", op_tready, 0);
        check("bp_s_tready", s_a_tready, 0);
        check("bp_valid", o_valid, 1);
      end
      if (first && !o_valid && beats_out - start < n) bubbles++;
      if (o_valid) first = 1;
      ah = a_v && a_tready; bh = b_v && b_tready;
      oh = op_v && op_tready; sh_hs = s_v && s_a_tready;
      step();
      if (ah) begin a_v = 0; sa++; end
      if (bh) begin b_v = 0; sb++; end
      if (oh) begin op_v = 0; so++; end
      if (sh_hs) begin s_v = 0; ss++; end
      done = (beats_out - start == n) && (s_beats - s_start == n);
    end
    a_v = 0; b_v = 0; op_v = 0; s_v = 0; a_l = 0; b_l = 0; op_l = 0; s_l = 0;
    check("stream_beats", beats_out - start, n);
    check("stream_s_beats", s_beats - s_start, n);
    if (!gaps && stall == 0) check("stream_bubbles", bubbles, 0);
  endtask

  initial begin
    rst = 1; rdy = 1;
    a_v = 1; b_v = 1; op_v = 1; s_v = 1;
    a_d = 32'h1111_1111; b_d = 32'h2222_2222; op_d = 8'h33; s_d = 32'h4444_4444;
    a_l = 0; b_l = 0; op_l = 0; s_l = 0;
    @(posedge clk);
    #1;

    // Reset with all tvalid high
    for (int i = 0; i < 3; i++) begin
      check("rst_a_tready", a_tready, 0);
      check("rst_b_tready", b_tready, 0);
      check("rst_op_tready", op_tready, 0);
      check("rst_s_tready", s_a_tready, 0);
      check("rst_valid", o_valid, 0);
      check("rst_s_valid", s_valid, 0);
      check("rst_data", {o_a, o_b}, 0);
      check("rst_op", o_op, 0);
      step();
    end
    rst = 0; a_v = 0; b_v = 0; op_v = 0; s_v = 0;
    step();
    check("rel_a_tready", a_tready, 1);
    check("rel_b_tready", b_tready, 1);
    check("rel_op_tready", op_tready, 1);
    check("rel_s_tready", s_a_tready, 1);
    check("rel_s_b_tready", s_b_tready, 0);
    check("rel_s_op_tready", s_op_tready, 0);

    // Single aligned beat
    a_v = 1; a_d = 32'h3F80_0000; b_v = 1; b_d = 32'h4000_0000; op_v = 1; op_d = 8'h01;
    step();
    a_v = 0; b_v = 0; op_v = 0;
    check("single_early", o_valid, 0);
    step();
    check("single_valid", o_valid, 1);
    check("single_a", o_a, 32'h3F80_0000);
    check("single_b", o_b, 32'h4000_0000);
    check("single_op", o_op, 8'h01);
    step();
    check("single_once", o_valid, 0);

    // Skewed arrival: A first (two beats), B three cycles later, op two more after that
    a_v = 1; a_d = 32'hA000_0000; step();
    a_d = 32'hA000_0001; step();
    check("skew_a_full", a_tready, 0);
    a_v = 0; step();
    b_v = 1; b_d = 32'hB000_0000; step();
    b_v = 0; step();
    check("skew_wait", o_valid, 0);
    op_v = 1; op_d = 8'h5A; step();
    op_v = 0;
    check("skew_early", o_valid, 0);
    step();
    check("skew_valid", o_valid, 1);
    check("skew_a", o_a, 32'hA000_0000);
    check("skew_b", o_b, 32'hB000_0000);
    check("skew_op", o_op, 8'h5A);
    b_v = 1; b_d = 32'hB000_0001; op_v = 1; op_d = 8'hA5; step();
    b_v = 0; op_v = 0;
    for (int i = 0; i < 3; i++) step();
    check("skew_drained_ready", a_tready, 1);

    // Back-pressure with five beats per channel
    stream(5, 10, 200, 0);
    // Continuous streaming
    stream(100, 0, 400, 0);
    // Random valid gaps and random downstream ready
    stream(60, 0, 2000, 1);

    // Reset mid-transfer discards buffered beats
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      a_v = 1; b_v = 1; op_v = 1; s_v = 1;
      a_d = $urandom; b_d = $urandom; op_d = 8'($urandom); s_d = $urandom;
      step();
    end
    rst = 1; a_v = 0; b_v = 0; op_v = 0; s_v = 0;
    step();
    step();
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_tready", a_tready, 0);
    qa.delete(); qb.delete(); qo.delete(); sq.delete();
    qla.delete(); qlb.delete(); qlo.delete(); sql.delete();
    held = 0; s_held = 0;
    rst = 0; rdy = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_valid", o_valid, 0);
      check("post_rst_s_valid", s_valid, 0);
    end
    check("post_rst_tready", a_tready, 1);

    check("drain_a", qa.size(), 0);
    check("drain_b", qb.size(), 0);
    check("drain_op", qo.size(), 0);
    check("drain_s", sq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
